cic_dec_ctrl: RTL and testbench
===============================

CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, giving the CIC output sample width.
REQ-002 The block SHALL have parameter RATIO_W, default 8, giving the decimation ratio field width.
REQ-003 The block SHALL have parameter SETTLE_N, default 3, giving the number of decimated samples discarded after start (the filter order).
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, declared as follows:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have the following remaining ports:
- enable  in  1  run request; level-sensitive.
- cfg_ratio  in  RATIO_W  requested decimation ratio R.
- cfg_load  in  1  one-cycle strobe that latches cfg_ratio into the shadow register.
- cic_out  in  DATA_W  filter output sample.
- dec_clk  out  1  one-cycle decimation strobe, driven to the filter.
- filt_rst  out  1  filter flush, driven to the filter's rst.
- sample_data  out  DATA_W  captured decimated sample.
- sample_valid  out  1  sample_data holds an unconsumed sample.
- sample_ready  in  1  downstream accepts the sample.
- overrun  out  1  sticky flag: a sample was dropped.
- overrun_clr  in  1  clears overrun.
- state  out  2  FSM state: IDLE=0, FLUSH=1, SETTLE=2, RUN=3.

Function
REQ-006 The FSM SHALL have four states, with the following transitions:
- IDLE -> FLUSH when enable=1.
- FLUSH -> SETTLE after exactly 1 cycle.
- SETTLE -> RUN on the cycle the SETTLE_N-th discarded capture occurs.
- Any state -> IDLE on the cycle after enable=0 is sampled.
REQ-007 filt_rst SHALL be 1 while in IDLE or FLUSH, and 0 otherwise.
REQ-008 The phase counter SHALL count from 0 to Ra-1 in SETTLE and RUN, and SHALL be held at 0 otherwise.
- dec_clk=1 exactly on the cycles where counter==Ra-1; the counter then wraps to 0.
- Strobe period is Ra clk cycles.
REQ-009 The active ratio Ra SHALL be max(shadow,2); a shadow value of 0 or 1 SHALL behave as 2.
REQ-010 The shadow register SHALL load on cfg_load.
- Ra takes the shadow value immediately in IDLE or FLUSH.
- In SETTLE or RUN, Ra takes the shadow value only on the dec_clk cycle, so the current period always completes at the old ratio.
REQ-011 cfg_load coinciding with a dec_clk cycle SHALL make the new value effective for the immediately following period.
REQ-012 A capture SHALL occur on the cycle after each dec_clk pulse, sampling cic_out (fixed latency of 1 cycle).
REQ-013 Captures in SETTLE SHALL be discarded and counted; captures in RUN SHALL be offered to the output.
REQ-014 A RUN capture with sample_valid=0, or with sample_valid=1 and sample_ready=1 in the same cycle, SHALL load sample_data and set sample_valid=1.
REQ-015 A RUN capture with sample_valid=1 and sample_ready=0 SHALL be dropped; sample_data SHALL be unchanged and overrun SHALL be set.
REQ-016 When sample_valid=1 and sample_ready=1 with no capture, sample_valid SHALL clear on the next cycle.
REQ-017 sample_data SHALL remain stable while sample_valid=1 and sample_ready=0.
REQ-018 overrun_clr SHALL clear overrun; if overrun_clr and a new overrun event occur in the same cycle, overrun SHALL remain 1.
REQ-019 Entering IDLE SHALL clear sample_valid, clear the settle count and zero the phase counter.
- overrun is retained in IDLE; it is cleared only by rst or overrun_clr.
- sample_data is held.
REQ-020 A capture pending on the same cycle enable drops SHALL be discarded.

Reset
REQ-021 On rst=1 the outputs and registers SHALL take the following values:
- state = IDLE, filt_rst = 1, dec_clk = 0.
- sample_valid = 0, sample_data = 0, overrun = 0.
- shadow ratio = 2, phase counter = 0, settle count = 0.
REQ-022 rst SHALL take priority over every other input, including mid-period and during a pending capture.

Structure
REQ-023 The state encoding constants, the minimum ratio (2) and the default SETTLE_N SHALL live in a shared package, cic_pkg.
REQ-024 The phase counter and ratio shadowing SHALL be a sub-module, dec_rate_gen, with ports clk, rst, run, ratio, load, strobe.
REQ-025 The FSM, capture logic and handshake logic SHALL remain in cic_dec_ctrl.

Verification
REQ-026 Start-up: rst, then cfg_ratio=4 with cfg_load, then enable=1 -> filt_rst 1 through the FLUSH cycle; dec_clk every 4 cycles; first 3 captures dropped; state=RUN after the 3rd; 4th capture appears on sample_data with sample_valid=1.
REQ-027 Ratio clamp: cfg_ratio=0, then 1 -> dec_clk period is 2 cycles in both cases.
REQ-028 Ratio change mid-run: R=8 in RUN, cfg_load R=3 at phase 2 -> the current period still totals 8 cycles, and subsequent periods are 3 cycles.
REQ-029 Backpressure: R=2, sample_ready=0 for 3 strobes after valid -> sample_data holds the first sample, overrun=1; overrun_clr with no new event -> overrun=0.
REQ-030 Simultaneous accept: sample_ready=1 on the capture cycle -> the new sample replaces the old, sample_valid stays 1, overrun stays 0.
REQ-031 Abort and reset: enable=0 mid-SETTLE -> IDLE next cycle, filt_rst=1, sample_valid=0; rst mid-RUN -> all values per REQ-021 on the next cycle.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator controller: FSM state
// encoding, the smallest usable decimation ratio and the default
// number of settling samples (the filter order).
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } cic_state_e;

    // Ratios below this are treated as this value.
    localparam int MIN_RATIO = 2;

    // Decimated samples thrown away after start while the integrators settle.
    localparam int DEFAULT_SETTLE_N = 3;

endpackage

// File: rtl/dec_rate_gen.sv
// Decimation phase counter with a shadowed ratio register.
// The shadow loads whenever load is high. While stopped, the active
// ratio follows the shadow freely; while running, it only picks up the
// shadow on the strobe cycle, so a period in progress always finishes
// at the ratio it started with.
module dec_rate_gen
    import cic_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               load,
    output logic               strobe
);

    localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(MIN_RATIO);
    localparam logic [RATIO_W-1:0] ONE   = RATIO_W'(1);

    logic [RATIO_W-1:0] shadow_q;
    logic [RATIO_W-1:0] shadow_d;
    logic [RATIO_W-1:0] ra_q;
    logic [RATIO_W-1:0] ra_next;
    logic [RATIO_W-1:0] cnt_q;

    // A load on this very cycle is visible to the ratio update, so a load
    // coinciding with the strobe governs the very next period.
    assign shadow_d = load ? ratio : shadow_q;
    assign ra_next  = (shadow_d < MIN_R) ? MIN_R : shadow_d;
    assign strobe   = run && (cnt_q == (ra_q - ONE));

    // Shadow, active ratio and phase counter; counter is held at 0 when stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= MIN_R;
            ra_q     <= MIN_R;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (!run || strobe) begin
                ra_q  <= ra_next;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Control block for a CIC decimation filter: flushes the filter on start,
// generates the decimation strobe, discards the settling samples and then
// hands decimated samples downstream over a valid/ready register.
//
// Handshake: sample_valid=1 means sample_data holds a sample not yet taken;
// a transfer happens on any cycle with sample_valid=1 and sample_ready=1.
// sample_data never changes while sample_valid=1 and sample_ready=0; a new
// sample arriving then is dropped and flagged on the sticky overrun output.
module cic_dec_ctrl
    import cic_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int RATIO_W  = 8,
    parameter int SETTLE_N = DEFAULT_SETTLE_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_load,
    input  logic [DATA_W-1:0]  cic_out,
    output logic               dec_clk,
    output logic               filt_rst,
    output logic [DATA_W-1:0]  sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun,
    input  logic               overrun_clr,
    output logic [1:0]         state
);

    localparam int SETTLE_W = (SETTLE_N < 2) ? 1 : $clog2(SETTLE_N + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_N - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);

    cic_state_e          state_q;
    cic_state_e          state_d;
    logic                running;
    logic                gen_run;
    logic                strobe;
    logic                cap_pending_q;
    logic                capture;
    logic                run_capture;
    logic                drop;
    logic                settle_done;
    logic [SETTLE_W-1:0] settle_cnt_q;

    assign running = (state_q == ST_SETTLE) || (state_q == ST_RUN);

    // Dropping enable stops the counter at once, so it is already zero
    // when the FSM lands in IDLE.
    assign gen_run = running && enable;

    dec_rate_gen #(
        .RATIO_W (RATIO_W)
    ) u_rate_gen (
        .clk    (clk),
        .rst    (rst),
        .run    (gen_run),
        .ratio  (cfg_ratio),
        .load   (cfg_load),
        .strobe (strobe)
    );

    assign dec_clk  = strobe;
    assign filt_rst = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign state    = state_q;

    // The filter output is valid one cycle after the strobe; a capture on
    // a cycle where enable is low is thrown away.
    assign capture     = cap_pending_q && enable && running;
    assign run_capture = capture && (state_q == ST_RUN);
    assign drop        = run_capture && sample_valid && !sample_ready;
    assign settle_done = capture && (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);

    // Next-state logic: enable low always wins and returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_FLUSH;
                ST_FLUSH:  state_d = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_d = ST_RUN;
                ST_RUN:    state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Remember the strobe so the filter output is sampled one cycle later.
    always_ff @(posedge clk) begin
        if (rst) cap_pending_q <= 1'b0;
        else     cap_pending_q <= strobe;
    end

    // Count discarded captures during SETTLE; cleared whenever IDLE is next.
    always_ff @(posedge clk) begin
        if (rst || (state_d == ST_IDLE)) begin
            settle_cnt_q <= '0;
        end else if (capture && (state_q == ST_SETTLE)) begin
            settle_cnt_q <= settle_cnt_q + SETTLE_ONE;
        end
    end

    // Output sample register and its valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            sample_valid <= 1'b0;
        end else if (run_capture && (!sample_valid || sample_ready)) begin
            sample_data  <= cic_out;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun: a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)              overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Bench for cic_dec_ctrl: directed scenarios plus a long randomized run
// against a behavioural model that tracks cycles-left-in-period.
module tb_cic_dec_ctrl;

    localparam int DATA_W   = 24;
    localparam int RATIO_W  = 8;
    localparam int SETTLE_N = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [RATIO_W-1:0] cfg_ratio;
    logic              cfg_load;
    logic [DATA_W-1:0] cic_out;
    logic              dec_clk;
    logic              filt_rst;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              overrun_clr;
    logic [1:0]        state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model state
    int                m_mode;
    int                m_shadow;
    int                m_left;
    int                m_pending;
    int                m_discards;
    int                m_valid;
    logic [DATA_W-1:0] m_data;
    int                m_overrun;

    // Clock generation
    always #5 clk = ~clk;

    cic_dec_ctrl #(
        .DATA_W   (DATA_W),
        .RATIO_W  (RATIO_W),
        .SETTLE_N (SETTLE_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_ratio    (cfg_ratio),
        .cfg_load     (cfg_load),
        .cic_out      (cic_out),
        .dec_clk      (dec_clk),
        .filt_rst     (filt_rst),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .state        (state)
    );

    // Behavioural model, advanced once per rising edge with the inputs
    // that were applied during the cycle just ending.
    task automatic model_update();
        int running, strobe, capture, nmode, shadow_new, eff, evt;
        if (rst) begin
            m_mode = 0; m_shadow = 2; m_left = 0; m_pending = 0;
            m_discards = 0; m_valid = 0; m_data = '0; m_overrun = 0;
            return;
        end
        running    = (m_mode >= 2) && enable;
        strobe     = running && (m_left == 1);
        capture    = m_pending && enable && (m_mode >= 2);
        shadow_new = cfg_load ? int'(cfg_ratio) : m_shadow;
        eff        = (shadow_new < 2) ? 2 : shadow_new;
        if (!enable) nmode = 0;
        else if (m_mode == 0) nmode = 1;
        else if (m_mode == 1) nmode = 2;
        else if (m_mode == 2) nmode = (capture && (m_discards + 1 == SETTLE_N)) ? 3 : 2;
        else nmode = 3;
        evt = 0;
        if (!enable) m_valid = 0;
        else if (m_mode == 3 && capture) begin
            if (!m_valid || sample_ready) begin m_data = cic_out; m_valid = 1; end
            else evt = 1;
        end else if (m_valid && sample_ready) m_valid = 0;
        if (evt) m_overrun = 1;
        else if (overrun_clr) m_overrun = 0;
        if (nmode == 0) m_discards = 0;
        else if (m_mode == 2 && capture) m_discards++;
        if (!running || strobe) m_left = eff;
        else m_left--;
        m_shadow  = shadow_new;
        m_pending = strobe;
        m_mode    = nmode;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Load a ratio while stopped, then enable and advance into SETTLE.
    task automatic start_run(input int r);
        enable = 1'b0;
        tick();
        cfg_ratio = RATIO_W'(r); cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        while (dec_clk !== 1'b1 && n < budget) begin tick(); n++; end
        if (dec_clk !== 1'b1) n = -1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (sample_valid !== 1'b1 && n < budget) begin tick(); n++; end
        if (sample_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        cfg_ratio = '0; cic_out = '0;
        rst = 1'b1; enable = 1'b1; cfg_load = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0;
        tick();
        tests_run += 6;
        if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state); end
        if (filt_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_filt_rst got %b want 1", filt_rst); end
        if (dec_clk !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_clk got %b want 0", dec_clk); end
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        if (sample_data !== '0) begin tests_failed++; $display("FAIL reset_data got %h want 0", sample_data); end
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        logic [DATA_W-1:0] hist [0:39];
        logic [1:0]        st_hist [0:39];
        int k, strobes;
        for (int i = 0; i < 40; i++) begin hist[i] = '0; st_hist[i] = 2'd0; end
        do_reset();
        cfg_ratio = 8'd4; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; enable = 1'b1;
        tick();
        tests_run += 4;
        if (state !== 2'd1) begin tests_failed++; $display("FAIL startup_flush_state got %0d want 1", state); end
        if (filt_rst !== 1'b1) begin tests_failed++; $display("FAIL startup_flush_filt_rst got %b want 1", filt_rst); end
        tick();
        if (state !== 2'd2) begin tests_failed++; $display("FAIL startup_settle_state got %0d want 2", state); end
        if (filt_rst !== 1'b0) begin tests_failed++; $display("FAIL startup_settle_filt_rst got %b want 0", filt_rst); end
        k = 0; strobes = 0;
        while (!sample_valid && k < 40) begin
            hist[k] = DATA_W'($urandom);
            cic_out = hist[k];
            st_hist[k] = state;
            if (dec_clk) strobes++;
            tick();
            k++;
        end
        tests_run += 5;
        if (k != 17) begin tests_failed++; $display("FAIL startup_valid_latency got %0d want 17", k); end
        if (strobes != 4) begin tests_failed++; $display("FAIL startup_strobes got %0d want 4", strobes); end
        if (st_hist[12] !== 2'd2) begin tests_failed++; $display("FAIL startup_state_at_3rd got %0d want 2", st_hist[12]); end
        if (st_hist[13] !== 2'd3) begin tests_failed++; $display("FAIL startup_state_after_3rd got %0d want 3", st_hist[13]); end
        if (sample_data !== hist[16]) begin tests_failed++; $display("FAIL startup_4th_sample got %h want %h", sample_data, hist[16]); end
    endtask

    task automatic test_clamp();
        int w1, w2;
        for (int r = 0; r < 2; r++) begin
            start_run(r);
            wait_strobe(20, w1);
            tick();
            wait_strobe(20, w2);
            tests_run++;
            if (w1 < 0 || (w2 + 1) != 2) begin
                tests_failed++; $display("FAIL clamp_period ratio %0d got %0d want 2", r, w2 + 1);
            end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_ratio_change();
        int w, t0, t1, t2, t3, t4;
        do_reset();
        sample_ready = 1'b1;
        start_run(8);
        w = 0;
        while (state !== 2'd3 && w < 200) begin tick(); w++; end
        tests_run++;
        if (state !== 2'd3) begin tests_failed++; $display("FAIL ratio_change_reach_run got %0d want 3", state); end
        wait_strobe(20, w);
        t0 = cyc;
        tick(); tick(); tick();
        cfg_ratio = 8'd3; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_strobe(20, w); t1 = cyc;
        tick();
        wait_strobe(20, w); t2 = cyc;
        cfg_ratio = 8'd5; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_strobe(20, w); t3 = cyc;
        tick();
        wait_strobe(20, w); t4 = cyc;
        tests_run += 4;
        if (t1 - t0 != 8) begin tests_failed++; $display("FAIL ratio_change_old_period got %0d want 8", t1 - t0); end
        if (t2 - t1 != 3) begin tests_failed++; $display("FAIL ratio_change_new_period got %0d want 3", t2 - t1); end
        if (t3 - t2 != 5) begin tests_failed++; $display("FAIL ratio_load_on_strobe got %0d want 5", t3 - t2); end
        if (t4 - t3 != 5) begin tests_failed++; $display("FAIL ratio_load_on_strobe_next got %0d want 5", t4 - t3); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] first;
        int w;
        do_reset();
        sample_ready = 1'b0;
        start_run(2);
        wait_valid(100, w);
        first = sample_data;
        tests_run += 2;
        if (w < 0) begin tests_failed++; $display("FAIL bp_first_valid timed out"); end
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_overrun_initial got %b want 0", overrun); end
        for (int i = 0; i < 3; i++) begin
            wait_strobe(20, w);
            cic_out = ~first;
            tick();
            tick();
            tests_run += 2;
            if (sample_data !== first) begin tests_failed++; $display("FAIL bp_data_hold got %h want %h", sample_data, first); end
            if (sample_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold got %b want 1", sample_valid); end
        end
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL bp_overrun_set got %b want 1", overrun); end
        wait_strobe(20, w);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_overrun_clr got %b want 0", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tests_run += 2;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL bp_clr_vs_event got %b want 1", overrun); end
        if (sample_data !== first) begin tests_failed++; $display("FAIL bp_data_after_drop got %h want %h", sample_data, first); end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        tests_run++;
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_accept_clears got %b want 0", sample_valid); end
        enable = 1'b0;
        tick();
        tests_run += 2;
        if (state !== 2'd0) begin tests_failed++; $display("FAIL bp_idle_state got %0d want 0", state); end
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL bp_overrun_kept_idle got %b want 1", overrun); end
    endtask

    task automatic test_simultaneous_accept();
        logic [DATA_W-1:0] first, x;
        int w;
        do_reset();
        sample_ready = 1'b0;
        start_run(4);
        wait_valid(100, w);
        first = sample_data;
        wait_strobe(20, w);
        tick();
        x = ~first;
        cic_out = x;
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        tests_run += 3;
        if (sample_data !== x) begin tests_failed++; $display("FAIL simul_data got %h want %h", sample_data, x); end
        if (sample_valid !== 1'b1) begin tests_failed++; $display("FAIL simul_valid got %b want 1", sample_valid); end
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL simul_overrun got %b want 0", overrun); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] d;
        int w;
        do_reset();
        start_run(4);
        tick(); tick();
        tests_run++;
        if (state !== 2'd2) begin tests_failed++; $display("FAIL abort_in_settle got %0d want 2", state); end
        enable = 1'b0;
        tick();
        tests_run += 3;
        if (state !== 2'd0) begin tests_failed++; $display("FAIL abort_state got %0d want 0", state); end
        if (filt_rst !== 1'b1) begin tests_failed++; $display("FAIL abort_filt_rst got %b want 1", filt_rst); end
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_valid got %b want 0", sample_valid); end
        sample_ready = 1'b0;
        enable = 1'b1;
        tick();
        wait_valid(100, w);
        wait_strobe(20, w);
        tick();
        d = sample_data;
        cic_out = ~d;
        sample_ready = 1'b1;
        enable = 1'b0;
        tick();
        sample_ready = 1'b0;
        tests_run += 3;
        if (state !== 2'd0) begin tests_failed++; $display("FAIL abort_run_state got %0d want 0", state); end
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_run_valid got %b want 0", sample_valid); end
        if (sample_data !== d) begin tests_failed++; $display("FAIL abort_capture_discard got %h want %h", sample_data, d); end
    endtask

    task automatic test_reset_mid_run();
        int w, w2;
        do_reset();
        sample_ready = 1'b0;
        start_run(5);
        wait_valid(200, w);
        w = 0;
        while (overrun !== 1'b1 && w < 100) begin tick(); w++; end
        tick(); tick();
        cfg_ratio = 8'd7; cfg_load = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; cfg_load = 1'b0;
        tests_run += 6;
        if (state !== 2'd0) begin tests_failed++; $display("FAIL rstrun_state got %0d want 0", state); end
        if (filt_rst !== 1'b1) begin tests_failed++; $display("FAIL rstrun_filt_rst got %b want 1", filt_rst); end
        if (dec_clk !== 1'b0) begin tests_failed++; $display("FAIL rstrun_dec_clk got %b want 0", dec_clk); end
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL rstrun_valid got %b want 0", sample_valid); end
        if (sample_data !== '0) begin tests_failed++; $display("FAIL rstrun_data got %h want 0", sample_data); end
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rstrun_overrun got %b want 0", overrun); end
        tick(); tick();
        wait_strobe(20, w);
        tick();
        wait_strobe(20, w2);
        tests_run++;
        if (w < 0 || (w2 + 1) != 2) begin tests_failed++; $display("FAIL rstrun_shadow_period got %0d want 2", w2 + 1); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 999) == 0);
            enable       = ($urandom_range(0, 99) != 0);
            cfg_load     = ($urandom_range(0, 49) == 0);
            cfg_ratio    = RATIO_W'($urandom_range(0, 9));
            cic_out      = DATA_W'($urandom);
            sample_ready = ($urandom_range(0, 2) != 0);
            overrun_clr  = ($urandom_range(0, 29) == 0);
            tick();
            tests_run += 6;
            if (state !== 2'(m_mode)) begin tests_failed++; $display("FAIL rand_state cyc %0d got %0d want %0d", cyc, state, m_mode); end
            if (filt_rst !== (m_mode <= 1)) begin tests_failed++; $display("FAIL rand_filt_rst cyc %0d got %b want %b", cyc, filt_rst, (m_mode <= 1)); end
            if (dec_clk !== ((m_mode >= 2) && enable && (m_left == 1))) begin
                tests_failed++; $display("FAIL rand_dec_clk cyc %0d got %b want %b", cyc, dec_clk, ((m_mode >= 2) && enable && (m_left == 1)));
            end
            if (sample_valid !== (m_valid != 0)) begin tests_failed++; $display("FAIL rand_valid cyc %0d got %b want %0d", cyc, sample_valid, m_valid); end
            if (sample_data !== m_data) begin tests_failed++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, sample_data, m_data); end
            if (overrun !== (m_overrun != 0)) begin tests_failed++; $display("FAIL rand_overrun cyc %0d got %b want %0d", cyc, overrun, m_overrun); end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_clamp();
        test_ratio_change();
        test_backpressure();
        test_simultaneous_accept();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
